// File: rtl/uart_bus_port_pkg.sv
// Shared register map, bit positions and TX FSM encoding for the buffered UART port.
package uart_bus_port_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_OVERRUN   = 2;
  localparam int ST_TX_IDLE      = 3;
  localparam int ST_TX_DROP      = 4;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  localparam int CTRL_CLR_FLAGS = 0;
  localparam int CTRL_FLUSH_RX  = 1;
  localparam int CTRL_FLUSH_TX  = 2;

  localparam int TX_WAIT_CYCLES = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAITBUSY,
    TX_WAITDONE
  } tx_state_t;

endpackage

// File: rtl/uart_bus_port_sync_fifo.sv
// Synchronous FIFO with combinational head, occupancy count and flush-then-push semantics.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    wr_idx;
  logic             do_push;
  logic             do_pop;
  logic             we;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the slot this cycle, so a full FIFO still accepts a concurrent push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign we      = flush ? push : do_push;
  assign wr_idx  = flush ? '0 : wr_ptr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/uart_bus_port.sv
// Memory-mapped buffered UART: bus-side DATA/STATUS/CTRL registers over TX and RX FIFOs,
// with a small FSM that hands bytes to an external uarttx.
module uart_bus_port #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        wen,
  input  logic [1:0]  waddr,
  input  logic [7:0]  wdata,
  input  logic        ren,
  input  logic [1:0]  raddr,
  output logic [31:0] rdata,
  output logic [7:0]  txchar,
  output logic        txen,
  input  logic        txbusy,
  input  logic [7:0]  rxchar,
  input  logic        rxdone,
  output logic        irq
);

  import uart_bus_port_pkg::*;

  logic          wen_q, ren_q;
  logic          wr_act, rd_act, ctrl_wr;
  logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic          rx_pop, rx_flush, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          rx_overrun, tx_drop;
  logic          rx_drop_ev, tx_drop_ev, flag_clr;
  logic          tx_idle;
  logic [31:0]   status, rd_val;
  tx_state_t     state, state_next;
  logic [1:0]    wait_cnt;

  // Strobes may be held across stalled cycles; only the rising edge acts.
  assign wr_act  = wen && !wen_q;
  assign rd_act  = ren && !ren_q;
  assign ctrl_wr = wr_act && (waddr == REG_CTRL);

  assign tx_push  = wr_act && (waddr == REG_DATA);
  assign tx_flush = ctrl_wr && wdata[CTRL_FLUSH_TX];
  assign rx_flush = ctrl_wr && wdata[CTRL_FLUSH_RX];
  assign flag_clr = ctrl_wr && wdata[CTRL_CLR_FLAGS];
  assign rx_pop   = rd_act && (raddr == REG_DATA) && !rx_empty;

  assign rx_drop_ev = rxdone && rx_full && !rx_pop && !rx_flush;
  assign tx_drop_ev = tx_push && tx_full && !tx_pop && !tx_flush;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (wdata),
    .dout  (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (rxdone),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rxchar),
    .dout  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign tx_idle = tx_empty && (state == TX_IDLE) && !txbusy;
  assign irq     = !rx_empty || rx_overrun;

  always_comb begin
    status                              = '0;
    status[ST_RX_NONEMPTY]              = !rx_empty;
    status[ST_TX_FULL]                  = tx_full;
    status[ST_RX_OVERRUN]               = rx_overrun;
    status[ST_TX_IDLE]                  = tx_idle;
    status[ST_TX_DROP]                  = tx_drop;
    status[ST_RX_COUNT_LSB +: CW]       = rx_count;
    status[ST_TX_COUNT_LSB +: CW]       = tx_count;
  end

  always_comb begin
    rd_val = '0;
    case (raddr)
      REG_DATA:   rd_val = rx_empty ? 32'h0 : {24'h0, rx_head};
      REG_STATUS: rd_val = status;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      rdata      <= '0;
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      wen_q      <= wen;
      ren_q      <= ren;
      rx_overrun <= (rx_overrun && !flag_clr) || rx_drop_ev;
      tx_drop    <= (tx_drop && !flag_clr) || tx_drop_ev;
      // Hold while ren stays high: re-sampling would expose a head that was never returned.
      if (rd_act)   rdata <= rd_val;
      else if (!ren) rdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= TX_IDLE;
      wait_cnt <= '0;
      txchar   <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == TX_WAITBUSY) ? wait_cnt + 2'd1 : 2'd0;
      if (tx_pop) txchar <= tx_head;
    end
  end

  always_comb begin
    state_next = state;
    tx_pop     = 1'b0;
    txen       = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!tx_empty && !txbusy) begin
          tx_pop     = 1'b1;
          state_next = TX_START;
        end
      end
      TX_START: begin
        txen       = 1'b1;
        state_next = TX_WAITBUSY;
      end
      TX_WAITBUSY: begin
        // If busy never shows up, fall back to IDLE; txchar only changes on a fresh pop.
        if (txbusy)
          state_next = TX_WAITDONE;
        else if (wait_cnt == 2'(TX_WAIT_CYCLES - 1))
          state_next = TX_IDLE;
      end
      TX_WAITDONE: begin
        if (!txbusy) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_port.sv
// Self-checking bench for uart_bus_port: register table, uarttx model with TX scoreboard,
// RX scoreboard and hand-written corner sequences.
module tb_uart_bus_port;
  import uart_bus_port_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        n_rst, wen, ren, txen, txbusy, rxdone, irq;
  logic [1:0]  waddr, raddr;
  logic [7:0]  wdata, txchar, rxchar;
  logic [31:0] rdata;

  logic        hold_busy = 1'b0;
  int          model_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          txen_count = 0;
  logic        txen_prev = 1'b0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];

  typedef struct {
    bit          wr;
    bit          busy;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  uart_bus_port #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .wen    (wen),
    .waddr  (waddr),
    .wdata  (wdata),
    .ren    (ren),
    .raddr  (raddr),
    .rdata  (rdata),
    .txchar (txchar),
    .txen   (txen),
    .txbusy (txbusy),
    .rxchar (rxchar),
    .rxdone (rxdone),
    .irq    (irq)
  );

  // uarttx model: busy for 10 cycles after a start pulse, unaffected by the port's reset.
  assign txbusy = hold_busy | (model_cnt != 0);
  always @(posedge clk) begin
    if (txen) model_cnt <= 10;
    else if (model_cnt != 0) model_cnt <= model_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst === 1'b1 && txen === 1'b1) begin
      txen_count++;
      check("txen_single_cycle", {31'b0, txen_prev}, 32'h0);
      check("txen_after_busy_low", {31'b0, txbusy}, 32'h0);
      if (tx_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL txen_unexpected: txchar 0x%0h with no byte queued", txchar);
      end else begin
        check("txchar", {24'b0, txchar}, {24'b0, tx_q.pop_front()});
      end
    end
    txen_prev = txen;
  end

  function automatic logic [31:0] st(bit ne, bit full, bit ovr, bit idle, bit drop, int rxc, int txc);
    logic [31:0] v;
    v = '0;
    v[ST_RX_NONEMPTY] = ne;
    v[ST_TX_FULL]     = full;
    v[ST_RX_OVERRUN]  = ovr;
    v[ST_TX_IDLE]     = idle;
    v[ST_TX_DROP]     = drop;
    v = v | (32'(rxc) << ST_RX_COUNT_LSB) | (32'(txc) << ST_TX_COUNT_LSB);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    ren = 1'b1; raddr = a;
    tick();
    d = rdata;
    ren = 1'b0;
    tick();
  endtask

  task automatic rx_push(input logic [7:0] b);
    rxchar = b; rxdone = 1'b1;
    tick();
    rxdone = 1'b0;
  endtask

  logic [31:0] d;
  logic [7:0]  e;
  bit          exp_ovr;
  int          base;

  initial begin
    n_rst = 1'b0; wen = 1'b0; ren = 1'b0; waddr = '0; raddr = '0;
    wdata = '0; rxchar = '0; rxdone = 1'b0;
    repeat (3) tick();
    check("reset_rdata", rdata, 32'h0);
    check("reset_txen", {31'b0, txen}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_txchar", {24'b0, txchar}, 32'h0);
    n_rst = 1'b1;
    tick();

    vecs.push_back('{0, 0, REG_STATUS, 8'h00, st(0,0,0,1,0,0,0)});
    vecs.push_back('{0, 0, 2'd3,       8'h00, 32'h0});
    vecs.push_back('{0, 0, REG_DATA,   8'h00, 32'h0});
    vecs.push_back('{1, 0, REG_STATUS, 8'hFF, 32'h0});
    vecs.push_back('{0, 0, REG_STATUS, 8'h00, st(0,0,0,1,0,0,0)});
    vecs.push_back('{1, 0, 2'd3,       8'hFF, 32'h0});
    vecs.push_back('{0, 0, 2'd3,       8'h00, 32'h0});
    vecs.push_back('{0, 1, REG_STATUS, 8'h00, st(0,0,0,0,0,0,0)});
    vecs.push_back('{1, 1, REG_DATA,   8'h11, 32'h0});
    vecs.push_back('{0, 1, REG_STATUS, 8'h00, st(0,0,0,0,0,0,1)});
    vecs.push_back('{1, 1, REG_DATA,   8'h22, 32'h0});
    vecs.push_back('{0, 1, REG_STATUS, 8'h00, st(0,0,0,0,0,0,2)});
    vecs.push_back('{1, 1, REG_CTRL,   8'h04, 32'h0});
    vecs.push_back('{0, 1, REG_STATUS, 8'h00, st(0,0,0,0,0,0,0)});
    vecs.push_back('{0, 0, REG_STATUS, 8'h00, st(0,0,0,1,0,0,0)});
    for (int i = 0; i < vecs.size(); i++) begin
      hold_busy = vecs[i].busy;
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, d);
        check($sformatf("table[%0d]", i), d, vecs[i].exp);
      end
    end

    // Held write strobe pushes once; then fill to full and overflow.
    hold_busy = 1'b1;
    wen = 1'b1; waddr = REG_DATA; wdata = 8'h55;
    repeat (5) tick();
    wen = 1'b0;
    tick();
    bus_read(REG_STATUS, d);
    check("held_wen_count", d, st(0,0,0,0,0,0,1));
    for (int i = 0; i < DEPTH - 1; i++) bus_write(REG_DATA, 8'(i));
    bus_read(REG_STATUS, d);
    check("tx_full", d, st(0,1,0,0,0,0,DEPTH));
    bus_write(REG_DATA, 8'hEE);
    bus_read(REG_STATUS, d);
    check("tx_drop", d, st(0,1,0,0,1,0,DEPTH));
    bus_write(REG_CTRL, 8'h05);
    bus_read(REG_STATUS, d);
    check("tx_flush_clear", d, st(0,0,0,0,0,0,0));
    hold_busy = 1'b0;
    tick();

    // TX sequence against the uarttx model.
    txen_count = 0;
    foreach (vecs[i]) ;
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(8'h41 + 8'(i));
      bus_write(REG_DATA, 8'h41 + 8'(i));
    end
    for (int k = 0; k < 400 && (tx_q.size() != 0 || model_cnt != 0); k++) tick();
    repeat (3) tick();
    check("tx_drain", 32'(tx_q.size()), 32'h0);
    check("txen_count", 32'(txen_count), 32'd3);
    bus_read(REG_STATUS, d);
    check("tx_idle_end", d, st(0,0,0,1,0,0,0));

    // RX overrun with DEPTH+1 bytes.
    exp_ovr = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (rx_q.size() < DEPTH) rx_q.push_back(8'(i));
      else exp_ovr = 1'b1;
      rx_push(8'(i));
    end
    tick();
    bus_read(REG_STATUS, d);
    check("rx_overrun_status", d, st(1,0,exp_ovr,1,0,rx_q.size(),0));
    check("irq_rx", {31'b0, irq}, 32'h1);
    for (int i = 0; i <= DEPTH; i++) begin
      bus_read(REG_DATA, d);
      e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
      check($sformatf("rx_read[%0d]", i), d, {24'b0, e});
    end
    bus_read(REG_STATUS, d);
    check("rx_empty_ovr", d, st(0,0,1,1,0,0,0));
    check("irq_ovr", {31'b0, irq}, 32'h1);
    bus_write(REG_CTRL, 8'h01);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(REG_STATUS, d);
    check("ovr_cleared", d, st(0,0,0,1,0,0,0));

    // Full RX FIFO, rxdone on the same cycle as a DATA read edge.
    for (int i = 0; i < DEPTH; i++) begin
      rx_q.push_back(8'h80 + 8'(i));
      rx_push(8'h80 + 8'(i));
    end
    ren = 1'b1; raddr = REG_DATA; rxchar = 8'h90; rxdone = 1'b1;
    tick();
    check("coincide_rdata", rdata, {24'b0, rx_q.pop_front()});
    rx_q.push_back(8'h90);
    rxdone = 1'b0; ren = 1'b0;
    tick();
    bus_read(REG_STATUS, d);
    check("coincide_status", d, st(1,0,0,1,0,DEPTH,0));

    bus_write(REG_CTRL, 8'h02);
    rx_q.delete();
    bus_read(REG_STATUS, d);
    check("rx_flush", d, st(0,0,0,1,0,0,0));

    // Flush and push in the same cycle leave one entry.
    wen = 1'b1; waddr = REG_CTRL; wdata = 8'h02; rxchar = 8'h77; rxdone = 1'b1;
    tick();
    wen = 1'b0; rxdone = 1'b0;
    tick();
    bus_read(REG_STATUS, d);
    check("flush_push_status", d, st(1,0,0,1,0,1,0));
    bus_read(REG_DATA, d);
    check("flush_push_data", d, 32'h77);

    // Held DATA read pops once and holds its value.
    rx_q.push_back(8'h5A); rx_push(8'h5A);
    rx_q.push_back(8'h5B); rx_push(8'h5B);
    ren = 1'b1; raddr = REG_DATA;
    check("rdata_idle", rdata, 32'h0);
    tick();
    e = rx_q.pop_front();
    check("hold_data0", rdata, {24'b0, e});
    tick();
    check("hold_data1", rdata, {24'b0, e});
    tick();
    check("hold_data2", rdata, {24'b0, e});
    ren = 1'b0;
    tick();
    check("hold_data_release", rdata, 32'h0);
    bus_read(REG_STATUS, d);
    check("hold_single_pop", d, st(1,0,0,1,0,1,0));
    bus_read(REG_DATA, d);
    check("hold_next_data", d, {24'b0, rx_q.pop_front()});
    ren = 1'b1; raddr = REG_STATUS;
    tick();
    check("hold_status0", rdata, st(0,0,0,1,0,0,0));
    tick();
    check("hold_status1", rdata, st(0,0,0,1,0,0,0));
    ren = 1'b0;
    tick();
    check("hold_status_release", rdata, 32'h0);

    // Reset while the FSM waits on uarttx with 5 bytes still queued.
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_q.push_back(8'hA0 + 8'(i));
      bus_write(REG_DATA, 8'hA0 + 8'(i));
    end
    rx_push(8'h33);
    base = txen_count;
    hold_busy = 1'b0;
    for (int k = 0; k < 20 && txen_count == base; k++) tick();
    check("reset_test_txen_seen", 32'(txen_count), 32'(base + 1));
    tick();
    ren = 1'b1; raddr = REG_STATUS;
    tick();
    check("pre_reset_status", rdata, st(1,0,0,0,0,1,5));
    n_rst = 1'b0;
    #1;
    check("async_rst_txen", {31'b0, txen}, 32'h0);
    check("async_rst_rdata", rdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    tx_q.delete();
    ren = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    base = txen_count;
    repeat (40) tick();
    check("no_txen_after_reset", 32'(txen_count), 32'(base));
    bus_read(REG_STATUS, d);
    check("post_reset_status", d, st(0,0,0,1,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bus_port.md
Name: uart_bus_port

Overview:
- Memory-mapped buffered UART peripheral on the CPU data bus.
- Bus side is driven by a busdev decoder: strobe, decoded address, data. Phy side drives an existing uarttx instance and consumes an existing uartrx instance.
- Decouples CPU byte I/O from 9600 bps serial timing with a TX FIFO and an RX FIFO, plus status/control registers.
- Read data is zero when not selected, so it can be OR-ed onto bus_r_data.

Parameters:
- DEPTH, 16, entries per FIFO; power of two, 2..256.
- CW, $clog2(DEPTH)+1, width of the FIFO occupancy count.

Ports:
- clk  in  1  CPU clock.
- n_rst  in  1  asynchronous active-low reset.
- wen  in  1  write strobe from busdev; may stay high for several cycles.
- waddr  in  2  word select, devaddr[3:2].
- wdata  in  8  write data, bus_w_data[7:0].
- ren  in  1  read strobe from busdev; may stay high for several cycles.
- raddr  in  2  word select, devaddr[3:2].
- rdata  out  32  registered read data; zero when not reading.
- txchar  out  8  byte to uarttx.charin.
- txen  out  1  one-cycle start pulse to uarttx.txen.
- txbusy  in  1  uarttx.busy.
- rxchar  in  8  uartrx.charout.
- rxdone  in  1  uartrx.done; one-cycle pulse per received byte.
- irq  out  1  high while the RX FIFO is non-empty or the overrun flag is set.

Behaviour:
- Reset (async, n_rst low): both FIFOs empty; all flags 0; rdata=0; txchar=0; txen=0; irq=0; TX FSM in IDLE. Reset takes effect mid-transfer immediately; a byte already in the uarttx shifter completes on its own.
- Access qualification: a write acts once, on the first cycle of a wen high period (wen && !wen_q). A read acts once, on the first cycle of a ren high period. This prevents double push/pop when the core holds a strobe across gated cycles.
- Register map, by waddr/raddr:
  - 0 DATA, write: push wdata into the TX FIFO. If the FIFO is full, drop the byte and set tx_drop.
  - 0 DATA, read: rdata={24'b0, RX head}, then pop. If the RX FIFO is empty, return 0 and do not pop.
  - 1 STATUS, read: bit0 rx_nonempty, bit1 tx_full, bit2 rx_overrun, bit3 tx_idle (TX FIFO empty, FSM in IDLE, !txbusy), bit4 tx_drop, bits[8+CW-1:8] RX count, bits[16+CW-1:16] TX count, all other bits 0.
  - 2 CTRL, write: bit0 clears rx_overrun and tx_drop; bit1 flushes RX; bit2 flushes TX. A TX flush does not abort a byte already handed to uarttx.
  - 1 write and 3 read/write: ignored; reads return 0.
- Read latency: rdata is registered and valid on the cycle after ren rises. While ren stays high it holds the captured value; it must not re-sample, or a DATA read would show a popped head that was never returned. rdata returns to 0 on the cycle after ren falls.
- RX push: on rxdone, push rxchar. If the FIFO is full, drop the byte and set rx_overrun.
  - Pop and push in the same cycle: both take effect; count is unchanged. A full FIFO with a simultaneous pop accepts the push without overrun.
  - Flush and push in the same cycle: flush wins, then the push is applied, so count=1.
- TX push with a simultaneous FSM pop: both take effect.
- TX FSM:
  - IDLE: if the TX FIFO is non-empty and !txbusy, pop the head into txchar and go to START.
  - START: txen=1 for exactly one cycle, then go to WAITBUSY.
  - WAITBUSY: when txbusy=1 go to WAITDONE; otherwise return to IDLE after 4 cycles, which is safe because txchar is re-popped only on a new entry.
  - WAITDONE: when txbusy=0 go to IDLE.
  - Back-to-back bytes therefore have no gap beyond uarttx's own stop-bit handling.
- Pointers: log2(DEPTH)-bit wrap-around read/write indices. count=CW bits, range 0..DEPTH. Full when count==DEPTH.
- irq is combinational from registered state: rx_nonempty | rx_overrun.

Decomposition:
- Shared package/header constants: register word offsets (REG_DATA=0, REG_STATUS=1, REG_CTRL=2) and STATUS/CTRL bit indices, so firmware headers and the bench stay in sync.
- Sub-module sync_fifo (params WIDTH, DEPTH; ports clk, n_rst, push, pop, flush, din, dout (head, combinational), count, full, empty). It is instantiated twice, for TX and RX.

Test Plan:
- Write 0x41,0x42,0x43 to DATA with a uarttx model (busy 10 cycles after txen) -> txchar sequence 0x41,0x42,0x43; exactly 3 single-cycle txen pulses, each after busy falls; tx_idle=1 at the end.
- Hold wen high for 5 cycles on one DATA write of 0x55 -> TX count increments by exactly 1.
- Pulse rxdone 17 times (DEPTH=16), bytes 0x00..0x10 -> STATUS = rx_overrun=1, RX count=16; 16 DATA reads return 0x00..0x0F; the 17th read returns 0. CTRL write 0x1 clears overrun; irq=0.
- RX FIFO full; rxdone coincides with a DATA read rising edge -> no overrun; count stays 16; rdata=head.
- STATUS read with ren low afterwards -> rdata nonzero for exactly one cycle after ren rises, then 0 one cycle after ren falls.
- Assert n_rst low while FSM in WAITDONE with 5 bytes queued -> all counts 0, txen=0, rdata=0 immediately; no further txen after reset release.
